seq_divider: RTL and testbench

//   Parametrised multi-cycle restoring divider: one quotient bit per clock, WIDTH-bit operands.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 170 +++++++++++++++++
 tb/tb_seq_divider.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    // Width of the bit-position counter for a WIDTH-bit dividend.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// Single combinational restoring-division step: shift in one dividend bit, trial subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0]   w_rem_t;
    logic [WIDTH-1:0] w_diff;

    assign w_rem_t = {i_rem, i_bit};
    assign o_q     = (w_rem_t >= {1'b0, i_b});
    // When the subtract succeeds the true difference is below b, so WIDTH bits suffice.
    assign w_diff  = w_rem_t[WIDTH-1:0] - i_b;
    assign o_rem   = o_q ? w_diff : w_rem_t[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with start/busy/done handshake.
// Define DIV_SIGNED_EN to add the signed_op input and the FIX (sign correction) state.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_e       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz_pend;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic             w_accept;

`ifdef DIV_SIGNED_EN
    logic r_sgn;
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = signed_op & a[WIDTH-1];
    assign w_b_neg = signed_op & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
`endif

    assign w_accept = start & ~r_busy;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[r_count]),
        .i_b   (r_dvs),
        .o_rem (w_rem_next),
        .o_q   (w_qbit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
`ifdef DIV_SIGNED_EN
            r_sgn      <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_dbz      <= 1'b0;
                        r_count    <= CW'(WIDTH - 1);
                        r_rem      <= '0;
                        r_quo      <= '0;
                        r_dbz_pend <= (b == '0);
                        // On divide-by-zero the raw dividend is kept so r can return it as-is.
                        r_dvd      <= (b == '0) ? a : w_a_mag;
                        r_dvs      <= w_b_mag;
`ifdef DIV_SIGNED_EN
                        r_sgn      <= signed_op;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
`endif
                    end
                end
                RUN: begin
                    if (r_dbz_pend) begin
                        r_dbz_pend <= 1'b0;
                        r_q        <= '1;
                        r_r        <= r_dvd;
                        r_dbz      <= 1'b1;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= DONE;
                    end else begin
                        r_rem   <= w_rem_next;
                        r_quo   <= {r_quo[WIDTH-2:0], w_qbit};
                        r_count <= r_count - CW'(1);
                        if (r_count == '0) begin
`ifdef DIV_SIGNED_EN
                            if (r_sgn) begin
                                r_state <= FIX;
                            end else begin
                                r_q     <= {r_quo[WIDTH-2:0], w_qbit};
                                r_r     <= w_rem_next;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= DONE;
                            end
`else
                            r_q     <= {r_quo[WIDTH-2:0], w_qbit};
                            r_r     <= w_rem_next;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
`endif
                        end
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    r_q     <= r_neg_q ? -r_quo : r_quo;
                    r_r     <= r_neg_r ? -r_rem : r_rem;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: randomized and directed operations against a plain-arithmetic model.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
`ifdef DIV_SIGNED_EN
    logic         sop = 1'b0;
`endif
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    logic mon_prev = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
`ifdef DIV_SIGNED_EN
        .signed_op   (sop),
`endif
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic ok, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference: plain arithmetic on the operands, latency from the documented timing.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sg, input int k);
        exp_t e;
        e.dbz = (y == '0);
        if (y == '0) begin
            e.q   = '1;
            e.r   = x;
            e.cyc = k + 1;
        end else if (sg) begin
            e.cyc = k + W + 1;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                e.q = x;
                e.r = '0;
            end else begin
                e.q = W'($signed(x) / $signed(y));
                e.r = W'($signed(x) % $signed(y));
            end
        end else begin
            e.q   = x / y;
            e.r   = x % y;
            e.cyc = k + W;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (done && !mon_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1'b0, 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("q", q == e.q, 64'(q), 64'(e.q));
                check("r", r == e.r, 64'(r), 64'(e.r));
                check("div_by_zero", div_by_zero == e.dbz, 64'(div_by_zero), 64'(e.dbz));
                check("latency", cyc == e.cyc, 64'(cyc), 64'(e.cyc));
                check("busy_at_done", busy == 1'b0, 64'(busy), 64'd0);
            end
        end
        mon_prev <= done;
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isg);
        logic eff;
        int   k;
`ifdef DIV_SIGNED_EN
        eff = isg;
`else
        eff = isg & 1'b0;
`endif
        @(negedge clock);
        start = 1'b1;
        a = ia;
        b = ib;
`ifdef DIV_SIGNED_EN
        sop = eff;
`endif
        @(posedge clock);
        #1;
        start = 1'b0;
        k = cyc;
        exp_q.push_back(model(ia, ib, eff, k));
        check("busy_after_accept", busy == 1'b1, 64'(busy), 64'd1);
        check("done_cleared", done == 1'b0, 64'(done), 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 1'b0, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         sg;

        repeat (3) @(negedge clock);
        check("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
        check("rst_done", done == 1'b0, 64'(done), 64'd0);
        check("rst_q", q == '0, 64'(q), 64'd0);
        check("rst_r", r == '0, 64'(r), 64'd0);
        check("rst_dbz", div_by_zero == 1'b0, 64'(div_by_zero), 64'd0);
        reset_n = 1'b1;

        issue(32'd100, 32'd7, 1'b0);
        wait_idle();
        issue(32'd5, 32'd0, 1'b0);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_idle();
        issue(32'd3, 32'd200, 1'b0);
        wait_idle();

        // Restart while busy must be ignored.
        issue(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clock);
        start = 1'b1;
        a = 32'd9;
        b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        // Back-to-back issue straight out of DONE.
        issue(32'd1234, 32'd10, 1'b0);
        wait_idle();
        issue(32'd77, 32'd77, 1'b0);
        wait_idle();

        // Reset mid-run discards the operation.
        issue(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy == 1'b0, 64'(busy), 64'd0);
        check("midrst_done", done == 1'b0, 64'(done), 64'd0);
        check("midrst_q", q == '0, 64'(q), 64'd0);
        check("midrst_r", r == '0, 64'(r), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (W + 5) @(negedge clock);
        check("no_done_after_reset", done == 1'b0, 64'(done), 64'd0);
        issue(32'd50, 32'd6, 1'b0);
        wait_idle();

`ifdef DIV_SIGNED_EN
        issue(-32'sd7, 32'd2, 1'b1);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        issue(-32'sd5, 32'd0, 1'b1);
        wait_idle();
        issue(-32'sd7, 32'd2, 1'b0);
        wait_idle();
`endif

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1, 2:    y = W'($urandom_range(1, 15));
                3:       y = x >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            sg = 1'($urandom_range(0, 1));
            issue(x, y, sg);
            wait_idle();
        end

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
